// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: frame FSM state encodings and default frame geometry.
// The optional parity stage is selected with the UART_RX_PARITY_EN macro.
package uart_rx_frame_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side UART bus: oversampling tick and serial line in, byte strobes out.
interface uart_rx_frame_if
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (input tick, rx, output data, valid, frame_err, parity_err, busy);
  modport slave  (output tick, rx, input data, valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take while rst is low.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: mid-bit sampling of 8N1 frames, LSB first, one-cycle result strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the payload and the stop bit.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input logic             clk,
  input logic             rst,
  uart_rx_frame_if.master bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxs;
  logic rxs_prev_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad_q, par_bad_d;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rxs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (bus.tick) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Edge detect runs every clk so the start bit is caught as early as possible.
        if (rxs_prev_q && !rxs) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (bus.tick && cnt_q == CNT_HALF) state_d = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bus.tick && cnt_q == CNT_FULL) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = ST_PARITY;
`else
          if (bit_q == BIT_LAST) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bus.tick && cnt_q == CNT_FULL) begin
          par_bad_d = rxs ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bus.tick && cnt_q == CNT_FULL) begin
          data_d = shift_q;
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
`endif
          if (rxs) begin
`ifdef UART_RX_PARITY_EN
            valid_d = !par_bad_q;
`else
            valid_d = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame-level model of expected strobes and stop-sample timing.
module tb_uart_rx_frame;
  import uart_rx_frame_pkg::*;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Ticks from START entry to the stop-bit sample, inclusive of the sampling tick.
  localparam int STOP_TICKS = (DB + 1) * OS + OS/2 - 1 + (PAR_EN ? OS : 0);

  typedef struct {
    logic [DB-1:0] data;
    logic          v;
    logic          fe;
    logic          pe;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  ev_t expq[$];
  ev_t cur;
  logic [DB-1:0] model_data;
  logic strobe;
  logic prev_strobe = 1'b0;
  int n_strobe = 0;
  int tick_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int tdiv;
    tdiv = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % TDIV;
      bus.tick = (tdiv == 0);
    end
  end

  // Ticks accepted while the receiver is busy, counted from the busy rise.
  always @(posedge clk) begin
    if (bus.busy !== 1'b1) tick_busy = 0;
    else if (bus.tick === 1'b1) tick_busy++;
  end

  always @(negedge clk) begin
    if (!rst) model_data = '0;
    strobe = bus.valid | bus.frame_err | bus.parity_err;
    if (strobe === 1'b1) begin
      n_strobe++;
      check("pulse_width", {31'd0, prev_strobe}, 32'd0);
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got data %0h v%0b fe%0b pe%0b expected none",
                 bus.data, bus.valid, bus.frame_err, bus.parity_err);
      end else begin
        cur = expq.pop_front();
        model_data = cur.data;
        check("data",       {24'd0, bus.data},         {24'd0, cur.data});
        check("valid",      {31'd0, bus.valid},        {31'd0, cur.v});
        check("frame_err",  {31'd0, bus.frame_err},    {31'd0, cur.fe});
        check("parity_err", {31'd0, bus.parity_err},   {31'd0, cur.pe});
        check("busy_at_strobe", {31'd0, bus.busy},     {31'd0, cur.fe});
        check("stop_tick",  tick_busy,                 STOP_TICKS);
      end
    end else begin
      check("data_hold", {24'd0, bus.data}, {24'd0, model_data});
    end
    prev_strobe = (strobe === 1'b1);
  end

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stopb);
    ev_t e;
    e.data = d;
    e.fe   = !stopb;
    e.pe   = PAR_EN && (par != ^d);
    e.v    = stopb && !e.pe;
    expq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stopb);
  endtask

  initial begin
    int snap;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data",  {24'd0, bus.data}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
    check("rst_perr",  {31'd0, bus.parity_err}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);

    // 0x55, good frame
    snap = n_strobe;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (BITCLK) @(negedge clk);
    check("t55_count", n_strobe - snap, 32'd1);
    check("t55_data", {24'd0, bus.data}, 32'h55);
    check("t55_busy", {31'd0, bus.busy}, 32'd0);

    // 5-tick low glitch
    snap = n_strobe;
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
    repeat (5 * TDIV - 10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    check("glitch_count", n_strobe - snap, 32'd0);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);
    check("glitch_data", {24'd0, bus.data}, 32'h55);

    // 0xA3 with a bad stop bit, then line held low
    snap = n_strobe;
    send_frame(8'hA3, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40 * TDIV) @(negedge clk);
    check("fe_count", n_strobe - snap, 32'd1);
    check("fe_data", {24'd0, bus.data}, 32'hA3);
    check("fe_busy_hold", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    check("fe_busy_release", {31'd0, bus.busy}, 32'd0);
    repeat (BITCLK) @(negedge clk);

    // back-to-back 0xA3, 0x0F
    snap = n_strobe;
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    repeat (BITCLK) @(negedge clk);
    check("b2b_count", n_strobe - snap, 32'd2);
    check("b2b_data", {24'd0, bus.data}, 32'h0F);

    // reset during bit 4 of 0xF0, released during bit 6
    snap = n_strobe;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    bus.rx = 1'b1;
    repeat (BITCLK/2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_data",  {24'd0, bus.data}, 32'd0);
    check("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    repeat (BITCLK/2 - 10 + BITCLK + BITCLK/2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (BITCLK/2 + BITCLK + BITCLK + 2 * BITCLK) @(negedge clk);
    check("mid_rst_count", n_strobe - snap, 32'd0);
    check("mid_rst_idle", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_hold", {24'd0, bus.data}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (BITCLK) @(negedge clk);
    check("post_rst_data", {24'd0, bus.data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    snap = n_strobe;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (BITCLK) @(negedge clk);
    check("par_bad_count", n_strobe - snap, 32'd1);
    check("par_bad_data", {24'd0, bus.data}, 32'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (BITCLK) @(negedge clk);
    check("par_good_count", n_strobe - snap, 32'd2);
`endif

    check("pending_events", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
